// File: rtl/elevator_drive.sv
// Three-floor elevator cab controller: accepts one-hot move commands, drives the motor and door.
// Optional completed-move counter enabled by defining ELEV_TRIP_COUNT_EN.
module elevator_drive #(
   parameter int unsigned FLOOR_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       d2,
   input  logic       d1,
   input  logic       n,
   input  logic       u1,
   input  logic       u2,
   output logic       motor_up,
   output logic       motor_dn,
   output logic       door_open,
   output logic [2:0] floor,
   output logic       done,
   output logic       cmd_err,
   output logic [7:0] trip_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MOVE = 2'd1;
   localparam logic [1:0] ST_DOOR = 2'd2;

   localparam logic [7:0] FLOOR_LAST = 8'(FLOOR_CYCLES - 1);
   localparam logic [7:0] DOOR_LAST  = 8'(DOOR_CYCLES - 1);

   logic [1:0] state;
   logic [7:0] tick;
   logic [1:0] steps_left;
   logic       dir_up;

   logic [2:0] bit_count;
   logic       in_range;
   logic       cmd_legal;
   logic       accept;
   logic [1:0] cmd_steps;
   logic       cmd_up;
   logic       door_last_tick;

   assign bit_count = {2'b00, d2} + {2'b00, d1} + {2'b00, n} + {2'b00, u1} + {2'b00, u2};

   // Target-floor check uses the one-hot floor directly: u2 only from 1, d2 only from 3.
   always_comb begin
      in_range = 1'b0;
      if (u2)
         in_range = floor[0];
      else if (u1)
         in_range = ~floor[2];
      else if (n)
         in_range = 1'b1;
      else if (d1)
         in_range = ~floor[0];
      else if (d2)
         in_range = floor[2];
   end

   assign cmd_legal      = (bit_count == 3'd1) && in_range;
   assign cmd_steps      = (u2 || d2) ? 2'd2 : 2'd1;
   assign cmd_up         = u1 || u2;
   assign cmd_ready      = (state == ST_IDLE);
   assign accept         = cmd_valid && cmd_ready;
   assign door_last_tick = (state == ST_DOOR) && (tick == DOOR_LAST);

   assign motor_up  = (state == ST_MOVE) && dir_up;
   assign motor_dn  = (state == ST_MOVE) && !dir_up;
   assign door_open = (state == ST_DOOR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         floor      <= 3'b001;
         tick       <= 8'd0;
         steps_left <= 2'd0;
         dir_up     <= 1'b0;
         done       <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         done    <= 1'b0;
         cmd_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  tick <= 8'd0;
                  if (!cmd_legal) begin
                     cmd_err <= 1'b1;
                  end else if (n) begin
                     state <= ST_DOOR;
                  end else begin
                     state      <= ST_MOVE;
                     steps_left <= cmd_steps;
                     dir_up     <= cmd_up;
                  end
               end
            end
            ST_MOVE: begin
               // The door opens on the same edge that lands the cab on its final floor.
               if (tick == FLOOR_LAST) begin
                  tick       <= 8'd0;
                  floor      <= dir_up ? {floor[1:0], 1'b0} : {1'b0, floor[2:1]};
                  steps_left <= steps_left - 2'd1;
                  if (steps_left == 2'd1)
                     state <= ST_DOOR;
               end else begin
                  tick <= tick + 8'd1;
               end
            end
            ST_DOOR: begin
               if (door_last_tick) begin
                  state <= ST_IDLE;
                  tick  <= 8'd0;
                  done  <= 1'b1;
               end else begin
                  tick <= tick + 8'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tick  <= 8'd0;
            end
         endcase
      end
   end

`ifdef ELEV_TRIP_COUNT_EN
   logic       is_move;
   logic [7:0] trips;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         is_move <= 1'b0;
      else if (accept)
         is_move <= !n;
   end

   // Door-open commands do not count as trips; the counter sticks at its maximum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         trips <= 8'h00;
      else if (door_last_tick && is_move && (trips != 8'hFF))
         trips <= trips + 8'h01;
   end

   assign trip_count = trips;
`else
   assign trip_count = 8'h00;
`endif

endmodule
